bridge_tx_arbiter: RTL and testbench

BRIDGE_TX_ARBITER -- requirements
Module: bridge_tx_arbiter

---
 rtl/bridge_pkg.sv | 35 +++
 rtl/bridge_credit_cnt.sv | 41 ++++
 rtl/bridge_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_bridge_tx_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the PCIe Tx credit arbiter.
// Requester indices, credit widths and the payload-length to data-credit conversion.
package bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StGap
  } arb_state_e;

  localparam int unsigned P      = 0;
  localparam int unsigned NP     = 1;
  localparam int unsigned CPL    = 2;
  localparam int unsigned NumReq = 3;

  localparam logic [2:0] FC_SEL_TX_AVAIL = 3'b100;

  localparam int unsigned HdrCreditW  = 8;
  localparam int unsigned DataCreditW = 12;
  localparam int unsigned DwPerCredit = 4;
  localparam int unsigned LenW        = 10;
  localparam int unsigned LenExtW     = LenW + 1;
  localparam int unsigned CostW       = 9;

  // Length field 0 encodes 1024 DW; cost is rounded up to whole credits.
  function automatic logic [CostW-1:0] data_cost(input logic has_data,
                                                 input logic [LenW-1:0] len);
    logic [LenExtW-1:0] dw;
    logic [LenExtW-1:0] credits;
    dw      = (len == '0) ? LenExtW'(1 << LenW) : {1'b0, len};
    credits = (dw + LenExtW'(DwPerCredit - 1)) / LenExtW'(DwPerCredit);
    return has_data ? credits[CostW-1:0] : '0;
  endfunction

endpackage

// File: rtl/bridge_credit_cnt.sv
// One flow-control credit counter: reload from a credit report, charge a cost, clamp at zero.
// A clear input empties the counter while the link is down.
module bridge_credit_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             charge,
  input  logic [Width-1:0] cost,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;
  logic [Width-1:0] base, sub;

  always_comb begin
    base = load ? load_val : count_q;
    sub  = charge ? cost : '0;
    if (clr) begin
      count_d = '0;
    end else if (base >= sub) begin
      count_d = base - sub;
    end else begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/bridge_tx_arbiter.sv
// Round-robin Tx arbiter for posted, non-posted and completion TLPs, gated by local
// copies of the link partner's available flow-control credits.
module bridge_tx_arbiter
  import bridge_pkg::*;
(
  input  logic                   Arb_CLK,
  input  logic                   Arb_RST,
  input  logic                   Arb_Link_Up,
  input  logic                   Arb_fc_valid,
  input  logic [HdrCreditW-1:0]  Arb_fc_ph,
  input  logic [HdrCreditW-1:0]  Arb_fc_nph,
  input  logic [HdrCreditW-1:0]  Arb_fc_cplh,
  input  logic [DataCreditW-1:0] Arb_fc_pd,
  input  logic [DataCreditW-1:0] Arb_fc_npd,
  input  logic [DataCreditW-1:0] Arb_fc_cpld,
  input  logic [2:0]             Arb_req,
  input  logic [2:0]             Arb_has_data,
  input  logic [LenW-1:0]        Arb_len_p,
  input  logic [LenW-1:0]        Arb_len_np,
  input  logic [LenW-1:0]        Arb_len_cpl,
  input  logic                   Arb_done,
  output logic [2:0]             Arb_grant,
  output logic                   Arb_busy,
  output logic [2:0]             Arb_fc_sel
);

  arb_state_e state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] ptr_q, ptr_d;

  logic [2:0][HdrCreditW-1:0]  hdr_cnt, hdr_rep;
  logic [2:0][DataCreditW-1:0] dat_cnt, dat_rep;
  logic [2:0][CostW-1:0]       dcost;
  logic [2:0][LenW-1:0]        len;
  logic [2:0]                  eligible;
  logic [2:0]                  charge;
  logic                        any_elig;
  logic [1:0]                  win;
  logic                        link_down;

  assign link_down = ~Arb_Link_Up;

  assign len[P]       = Arb_len_p;
  assign len[NP]      = Arb_len_np;
  assign len[CPL]     = Arb_len_cpl;
  assign hdr_rep[P]   = Arb_fc_ph;
  assign hdr_rep[NP]  = Arb_fc_nph;
  assign hdr_rep[CPL] = Arb_fc_cplh;
  assign dat_rep[P]   = Arb_fc_pd;
  assign dat_rep[NP]  = Arb_fc_npd;
  assign dat_rep[CPL] = Arb_fc_cpld;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'(CPL)) ? 2'(P) : idx + 2'd1;
  endfunction

  for (genvar i = 0; i < NumReq; i++) begin : g_req
    assign dcost[i]    = data_cost(Arb_has_data[i], len[i]);
    assign eligible[i] = Arb_Link_Up && Arb_req[i] && (hdr_cnt[i] != '0) &&
                         (dat_cnt[i] >= DataCreditW'(dcost[i]));

    bridge_credit_cnt #(
      .Width(HdrCreditW)
    ) u_hdr (
      .clk      (Arb_CLK),
      .rst      (Arb_RST),
      .clr      (link_down),
      .load     (Arb_fc_valid),
      .load_val (hdr_rep[i]),
      .charge   (charge[i]),
      .cost     (HdrCreditW'(1)),
      .count    (hdr_cnt[i])
    );

    bridge_credit_cnt #(
      .Width(DataCreditW)
    ) u_dat (
      .clk      (Arb_CLK),
      .rst      (Arb_RST),
      .clr      (link_down),
      .load     (Arb_fc_valid),
      .load_val (dat_rep[i]),
      .charge   (charge[i]),
      .cost     (DataCreditW'(dcost[i])),
      .count    (dat_cnt[i])
    );
  end

  // Search starts one past the last winner and wraps P -> NP -> CPL -> P.
  always_comb begin
    logic [1:0] cand;
    any_elig = 1'b0;
    win      = ptr_q;
    cand     = rr_next(ptr_q);
    for (int k = 0; k < int'(NumReq); k++) begin
      if (!any_elig && eligible[cand]) begin
        any_elig = 1'b1;
        win      = cand;
      end
      cand = rr_next(cand);
    end
  end

  always_ff @(posedge Arb_CLK) begin
    if (Arb_RST) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= 2'(CPL);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    charge  = '0;
    if (!Arb_Link_Up) begin
      state_d = StIdle;
      grant_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_elig) begin
            state_d = StBusy;
            grant_d = 3'b001 << win;
            ptr_d   = win;
            charge  = 3'b001 << win;
          end
        end
        StBusy: begin
          if (Arb_done) begin
            state_d = StGap;
            grant_d = '0;
          end
        end
        StGap: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          grant_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    Arb_grant  = grant_q;
    Arb_busy   = |grant_q;
    Arb_fc_sel = FC_SEL_TX_AVAIL;
  end

endmodule

// File: tb/tb_bridge_tx_arbiter.sv
// Self-checking bench for bridge_tx_arbiter: directed scenarios plus randomized traffic,
// all checked each cycle against a cycle-level behavioural model of the credit arbiter.
module tb_bridge_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst, link, fc_valid, done, busy;
  logic [7:0]  fc_ph, fc_nph, fc_cplh;
  logic [11:0] fc_pd, fc_npd, fc_cpld;
  logic [2:0]  req, has_data, grant, fc_sel;
  logic [9:0]  len_p, len_np, len_cpl;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: credit counts, current owner (-1 none), phase 0=idle 1=busy 2=gap.
  int m_hc[3];
  int m_dc[3];
  int m_owner, m_mode, m_last;

  always #5 clk = ~clk;

  bridge_tx_arbiter dut (
    .Arb_CLK      (clk),
    .Arb_RST      (rst),
    .Arb_Link_Up  (link),
    .Arb_fc_valid (fc_valid),
    .Arb_fc_ph    (fc_ph),
    .Arb_fc_nph   (fc_nph),
    .Arb_fc_cplh  (fc_cplh),
    .Arb_fc_pd    (fc_pd),
    .Arb_fc_npd   (fc_npd),
    .Arb_fc_cpld  (fc_cpld),
    .Arb_req      (req),
    .Arb_has_data (has_data),
    .Arb_len_p    (len_p),
    .Arb_len_np   (len_np),
    .Arb_len_cpl  (len_cpl),
    .Arb_done     (done),
    .Arb_grant    (grant),
    .Arb_busy     (busy),
    .Arb_fc_sel   (fc_sel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cost_of(input int i);
    int l;
    l = (i == 0) ? int'(len_p) : (i == 1) ? int'(len_np) : int'(len_cpl);
    if (!has_data[i]) return 0;
    if (l == 0) l = 1024;
    return (l + 3) / 4;
  endfunction

  function automatic int rep_h(input int i);
    return (i == 0) ? int'(fc_ph) : (i == 1) ? int'(fc_nph) : int'(fc_cplh);
  endfunction

  function automatic int rep_d(input int i);
    return (i == 0) ? int'(fc_pd) : (i == 1) ? int'(fc_npd) : int'(fc_cpld);
  endfunction

  task automatic model_edge();
    int win, hb, db;
    int c[3];
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_hc[i] = 0;
        m_dc[i] = 0;
      end
      m_owner = -1;
      m_mode  = 0;
      m_last  = 2;
      return;
    end
    for (int i = 0; i < 3; i++) c[i] = cost_of(i);
    win = -1;
    if (link && m_mode == 0) begin
      for (int k = 1; k <= 3; k++) begin
        int i;
        i = (m_last + k) % 3;
        if (win < 0 && req[i] && m_hc[i] >= 1 && m_dc[i] >= c[i]) win = i;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (!link) begin
        m_hc[i] = 0;
        m_dc[i] = 0;
      end else begin
        hb = fc_valid ? rep_h(i) : m_hc[i];
        db = fc_valid ? rep_d(i) : m_dc[i];
        if (i == win) begin
          hb = hb - 1;
          db = db - c[i];
        end
        m_hc[i] = (hb < 0) ? 0 : hb;
        m_dc[i] = (db < 0) ? 0 : db;
      end
    end
    if (!link) begin
      m_mode  = 0;
      m_owner = -1;
    end else if (m_mode == 0) begin
      if (win >= 0) begin
        m_mode  = 1;
        m_owner = win;
        m_last  = win;
      end
    end else if (m_mode == 1) begin
      if (done) begin
        m_mode  = 2;
        m_owner = -1;
      end
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic compare_all();
    check("grant", grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("busy", busy, (m_owner >= 0) ? 32'd1 : 32'd0);
    check("fc_sel", fc_sel, 32'd4);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hdr_cnt%0d", i), dut.hdr_cnt[i], m_hc[i]);
      check($sformatf("dat_cnt%0d", i), dut.dat_cnt[i], m_dc[i]);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic quiet();
    rst = 1'b0; link = 1'b1; fc_valid = 1'b0; done = 1'b0;
    req = '0; has_data = '0; len_p = '0; len_np = '0; len_cpl = '0;
    fc_ph = '0; fc_nph = '0; fc_cplh = '0; fc_pd = '0; fc_npd = '0; fc_cpld = '0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_fc(input int ph, input int nph, input int cplh,
                        input int pd, input int npd, input int cpld);
    fc_valid = 1'b1;
    fc_ph = 8'(ph); fc_nph = 8'(nph); fc_cplh = 8'(cplh);
    fc_pd = 12'(pd); fc_npd = 12'(npd); fc_cpld = 12'(cpld);
  endtask

  initial begin
    int held, zeros;
    logic [2:0] prev;
    logic [2:0] order[$];
    int gaps[$];

    do_reset();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_fc_sel", fc_sel, 3'b100);

    // Scenario 1: basic grant and charge.
    set_fc(4, 0, 0, 64, 0, 0);
    req = 3'b001; has_data = 3'b001; len_p = 10'd10;
    step();
    fc_valid = 1'b0;
    check("s1_no_grant_yet", grant, 0);
    step();
    check("s1_grant", grant, 3'b001);
    check("s1_ph", dut.hdr_cnt[0], 3);
    check("s1_pd", dut.dat_cnt[0], 61);

    // Scenario 2: fairness with a fixed done delay.
    do_reset();
    set_fc(200, 200, 200, 0, 0, 0);
    req = 3'b111;
    step();
    fc_valid = 1'b0;
    held = 0; zeros = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      prev = grant;
      step();
      if (grant != 0 && prev == 0) begin
        if (order.size() > 0) gaps.push_back(zeros);
        order.push_back(grant);
      end
      zeros = (grant == 0) ? zeros + 1 : 0;
      held  = (grant != 0) ? held + 1 : 0;
      done  = (held == 2);
    end
    done = 1'b0;
    check("s2_grant_count", (order.size() >= 4) ? 1 : 0, 1);
    if (order.size() >= 4) begin
      check("s2_order0", order[0], 3'b001);
      check("s2_order1", order[1], 3'b010);
      check("s2_order2", order[2], 3'b100);
      check("s2_order3", order[3], 3'b001);
      // Grant-free cycles between grants: the GAP cycle plus a single IDLE cycle.
      check("s2_gap", gaps[0], 2);
    end

    // Scenario 3: data-credit starvation of P while NP proceeds.
    do_reset();
    set_fc(4, 4, 0, 2, 0, 0);
    req = 3'b011; has_data = 3'b001; len_p = 10'd12;
    step();
    fc_valid = 1'b0;
    step();
    check("s3_np_grant", grant, 3'b010);
    req = 3'b001; done = 1'b1;
    step();
    done = 1'b0;
    step();
    check("s3_p_withheld", grant, 0);
    set_fc(4, 4, 0, 3, 0, 0);
    step();
    fc_valid = 1'b0;
    step();
    check("s3_p_grant", grant, 3'b001);
    check("s3_pd_after", dut.dat_cnt[0], 0);

    // Scenario 4: 1024-DW completion needs 256 data credits.
    do_reset();
    set_fc(0, 0, 4, 0, 0, 255);
    req = 3'b100; has_data = 3'b100; len_cpl = 10'd0;
    step();
    fc_valid = 1'b0;
    step();
    step();
    check("s4_no_grant", grant, 0);
    set_fc(0, 0, 4, 0, 0, 256);
    step();
    fc_valid = 1'b0;
    step();
    check("s4_grant", grant, 3'b100);
    check("s4_cpld", dut.dat_cnt[2], 0);

    // Scenario 5: credit report in the same cycle as a grant.
    do_reset();
    set_fc(1, 0, 0, 0, 0, 0);
    step();
    set_fc(5, 0, 0, 0, 0, 0);
    req = 3'b001;
    step();
    fc_valid = 1'b0;
    check("s5_grant", grant, 3'b001);
    check("s5_ph", dut.hdr_cnt[0], 4);

    // Scenario 6: link loss, then reset, while busy.
    link = 1'b0;
    step();
    check("s6_link_grant", grant, 0);
    check("s6_link_ph", dut.hdr_cnt[0], 0);
    link = 1'b1;
    set_fc(3, 3, 3, 8, 8, 8);
    step();
    fc_valid = 1'b0;
    step();
    check("s6_regrant", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("s6_rst_grant", grant, 0);
    check("s6_rst_ph", dut.hdr_cnt[0], 0);
    step();
    check("s6_idle_after_rst", grant, 0);

    // Randomized traffic.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst      = ($urandom_range(0, 199) == 0);
      link     = ($urandom_range(0, 29) != 0);
      fc_valid = ($urandom_range(0, 7) == 0);
      fc_ph    = 8'($urandom_range(0, 3));
      fc_nph   = 8'($urandom_range(0, 3));
      fc_cplh  = 8'($urandom_range(0, 3));
      fc_pd    = 12'($urandom_range(0, 300));
      fc_npd   = 12'($urandom_range(0, 300));
      fc_cpld  = 12'($urandom_range(0, 300));
      req      = 3'($urandom);
      has_data = 3'($urandom);
      len_p    = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom);
      len_np   = 10'($urandom_range(0, 40));
      len_cpl  = 10'($urandom);
      done     = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
